// File: rtl/bicubic_job_sched.sv
// Job queue and launch/watchdog sequencer for the Bicubic scaling engine.
// Jobs are bounds-checked against the 100x100 ROM before the engine is released.
module bicubic_job_sched #(
  parameter int unsigned DEPTH          = 4,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [6:0]                   job_v0,
  input  logic [6:0]                   job_h0,
  input  logic [4:0]                   job_sw,
  input  logic [4:0]                   job_sh,
  input  logic [5:0]                   job_tw,
  input  logic [5:0]                   job_th,
  input  logic [3:0]                   job_id,
  output logic [6:0]                   V0,
  output logic [6:0]                   H0,
  output logic [4:0]                   SW,
  output logic [4:0]                   SH,
  output logic [5:0]                   TW,
  output logic [5:0]                   TH,
  output logic                         eng_rst,
  input  logic                         eng_done,
  output logic                         st_valid,
  output logic [3:0]                   st_id,
  output logic [1:0]                   st_code,
  output logic [19:0]                  st_cycles,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   queue_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [6:0] v0;
    logic [6:0] h0;
    logic [4:0] sw;
    logic [4:0] sh;
    logic [5:0] tw;
    logic [5:0] th;
    logic [3:0] id;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_RUN,
    S_REPORT
  } state_t;

  job_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [LW-1:0] lvl_q;
  logic [LW-1:0] lvl_d;

  state_t        state_q;
  logic [3:0]    id_q;
  logic [19:0]   cnt_q;
  logic [19:0]   cnt_inc;

  job_t          job_in;
  job_t          head;
  logic          push;
  logic          pop;
  logic [7:0]    hsum;
  logic [7:0]    vsum;
  logic          job_ok;

  assign job_in = '{v0: job_v0, h0: job_h0, sw: job_sw, sh: job_sh,
                    tw: job_tw, th: job_th, id: job_id};
  assign head   = mem_q[rd_q];

  assign job_ready = (lvl_q < LW'(DEPTH)) && !RST;
  assign push      = job_valid && job_ready;
  assign pop       = (state_q == S_IDLE) && (lvl_q != '0);

  always_comb begin
    lvl_d = lvl_q;
    if (push && !pop) lvl_d = lvl_q + LW'(1);
    if (pop && !push) lvl_d = lvl_q - LW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= job_in;
  end

  // 8-bit sums so an origin near the edge cannot wrap back in range.
  assign hsum   = {1'b0, H0} + {3'b000, SW};
  assign vsum   = {1'b0, V0} + {3'b000, SH};
  assign job_ok = (SW >= 5'd2) && (SH >= 5'd2) &&
                  (TW >= 6'd2) && (TH >= 6'd2) &&
                  (hsum <= 8'd100) && (vsum <= 8'd100);

  assign cnt_inc = cnt_q + 20'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      V0        <= '0;
      H0        <= '0;
      SW        <= '0;
      SH        <= '0;
      TW        <= '0;
      TH        <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      st_valid  <= 1'b0;
      st_id     <= '0;
      st_code   <= '0;
      st_cycles <= '0;
    end else begin
      st_valid <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (lvl_q != '0) begin
            V0      <= head.v0;
            H0      <= head.h0;
            SW      <= head.sw;
            SH      <= head.sh;
            TW      <= head.tw;
            TH      <= head.th;
            id_q    <= head.id;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (job_ok) begin
            state_q <= S_LAUNCH;
          end else begin
            state_q   <= S_REPORT;
            st_valid  <= 1'b1;
            st_id     <= id_q;
            st_code   <= 2'b01;
            st_cycles <= '0;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_inc;
          // Done wins over a coincident timeout.
          if (eng_done) begin
            state_q   <= S_REPORT;
            st_valid  <= 1'b1;
            st_id     <= id_q;
            st_code   <= 2'b00;
            st_cycles <= cnt_inc;
          end else if (cnt_inc == TIMEOUT_CYCLES) begin
            state_q   <= S_REPORT;
            st_valid  <= 1'b1;
            st_id     <= id_q;
            st_code   <= 2'b10;
            st_cycles <= cnt_inc;
          end
        end
        S_REPORT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign eng_rst     = RST || (state_q != S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign queue_level = lvl_q;

endmodule
